renkon_ctrl_pool_wb: RTL

RENKON_CTRL_POOL_WB -- requirements
Module: renkon_ctrl_pool_wb

---
 rtl/renkon_ctrl_pool_wb_if.sv | 17 +
 rtl/renkon_ctrl_pool_wb.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/renkon_ctrl_pool_wb_if.sv
// ============================================================================
// Module   : ctrl_bus
// Brief    : start/valid/stop control stream between pooling and write-back.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ctrl_bus;
  logic start;
  logic valid;
  logic stop;

  modport master (output start, output valid, output stop);
  modport slave  (input  start, input  valid, input  stop);
endinterface

`default_nettype wire

// File: rtl/renkon_ctrl_pool_wb.sv
// ============================================================================
// Module   : renkon_ctrl_pool_wb
// Brief    : Writes a pooled map into output memory, raster order from a base.
//            Optional overflow guard: define RENKON_POOL_WB_OVF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module renkon_ctrl_pool_wb #(
  parameter int LWIDTH  = 10,
  parameter int MEMSIZE = 12,
  parameter int DWIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  ctrl_bus.slave             in_ctrl,
  input  logic [DWIDTH-1:0]  pool_data,
  input  logic [LWIDTH-1:0]  out_size,
  input  logic [MEMSIZE-1:0] out_base,
  output logic               mem_we,
  output logic [MEMSIZE-1:0] mem_addr,
  output logic [DWIDTH-1:0]  mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [LWIDTH-1:0]    size_q, size_d;
  logic [LWIDTH-1:0]    x_q, x_d;
  logic [LWIDTH-1:0]    y_q, y_d;
  logic [MEMSIZE-1:0]   addr_q, addr_d;
  logic                 mem_we_q, mem_we_d;
  logic [MEMSIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  logic [LWIDTH-1:0]    size_m1;
  logic                 x_last;
  logic                 y_last;
  logic                 wr_block;

  // A size of zero makes size_m1 all-ones, so the counters wrap at 2^LWIDTH.
  assign size_m1 = size_q - LWIDTH'(1);
  assign x_last  = (x_q == size_m1);
  assign y_last  = (y_q == size_m1);

`ifdef RENKON_POOL_WB_OVF_EN
  logic full_q, full_d;
  logic err_q, err_d;

  assign wr_block = full_q;

  always_comb begin
    full_d = full_q;
    err_d  = err_q;
    if (state_q == S_WAIT && in_ctrl.start) begin
      full_d = 1'b0;
      err_d  = 1'b0;
    end else if (state_q == S_ACTIVE && in_ctrl.valid) begin
      if (full_q) begin
        err_d = 1'b1;
      end else if (x_last && y_last) begin
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wr_block = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_WAIT: begin
        if (in_ctrl.start) begin
          state_d = S_ACTIVE;
          size_d  = out_size;
          x_d     = '0;
          y_d     = '0;
          addr_d  = out_base;
        end
      end
      S_ACTIVE: begin
        // A valid coinciding with stop is still written before leaving.
        if (in_ctrl.valid && !wr_block) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = pool_data;
          addr_d      = addr_q + MEMSIZE'(1);
          x_d         = x_last ? '0 : x_q + LWIDTH'(1);
          if (x_last) begin
            y_d = y_last ? '0 : y_q + LWIDTH'(1);
          end
        end
        if (in_ctrl.stop) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT;
      size_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == S_ACTIVE);
  assign done      = (state_q == S_DONE);

endmodule

`default_nettype wire
